pipe_addsub: RTL and testbench
==============================

Name: pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the FFT butterfly datapath.
- Successor to the fixed-width combinational adder, adding:
  - configurable width and pipeline depth
  - add/subtract mode
  - signed overflow detection and optional saturation
  - valid/ready flow control with back-pressure
- Operands are split into STAGES equal slices. Carry ripples between slices through pipeline registers, so each stage computes one slice's carry-lookahead.

Parameters:
- WIDTH, 32: operand/result width in bits. Must be a multiple of STAGES.
- STAGES, 4: pipeline stages, equal to the number of slices. Range 1..8. SLICE = WIDTH/STAGES, and SLICE must be at least 4.
- SAT_EN, 1: 1 builds the saturation logic; 0 ties it off and ignores the `sat` input.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept operands this cycle
- a  in  WIDTH  operand A, two's complement
- b  in  WIDTH  operand B, two's complement
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0: a+b+cin; 1: a-b-cin
- sat  in  1  saturate on signed overflow (needs SAT_EN=1)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out  out  WIDTH  result
- cout  out  1  raw carry out of the MSB; for sub, 1 means no borrow
- ovf  out  1  signed overflow flag, computed before saturation

Behaviour:
- Reset: asynchronous, active-low, no clock needed.
  - Every stage valid bit clears, so out_valid=0.
  - out, cout and ovf clear to 0. Data registers need not clear.
  - Operations in flight are discarded. Nothing is emitted after reset releases until new input is accepted.
- Effective operands: B' = sub ? ~b : b, and C0 = sub ? ~cin : cin. The sum is a + B' + C0.
- Global advance: adv = ~out_valid | out_ready, and in_ready = adv.
  - When adv=0, all pipeline registers hold (full stall). No bubble collapsing is required.
  - An input is accepted when in_valid & in_ready.
- Slice k (k = 0..STAGES-1) uses bits [k*SLICE +: SLICE]:
  - Stage k+1 computes slice k with carry-lookahead from the carry registered by stage k (stage 1 uses C0).
  - Inputs of slice k are skewed by k register stages. Sum bits of slice k are de-skewed by STAGES-1-k stages.
  - All slices of one transaction leave together.
- Latency: exactly STAGES clocks from the accepting edge to out_valid=1, with no stalls. Throughput is 1 per clock.
- With STAGES=1 the block is a single registered stage.
- Flags:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR cout.
- Saturation (SAT_EN=1, and `sat` captured with the transaction = 1, and ovf = 1):
  - The output is forced to the signed max 0x7FF..F if the effective operand MSBs (a, B') are both 0.
  - It is forced to the signed min 0x800..0 if they are both 1.
  - cout and ovf still report the raw values.
- Mode inputs sub and sat travel with their data. A per-transaction mode change needs no flush.
- When out_valid & ~out_ready, out, cout and ovf are stable until the handshake completes.
- Simultaneous accept and emit in the same cycle are allowed.
- Order is preserved. No loss, no duplication.

Decomposition:
- Shared package addsub_pkg:
  - default WIDTH/STAGES constants
  - derived SLICE localparam function
  - SAT_MAX/SAT_MIN constant functions of WIDTH
  - an elaboration-time check that WIDTH % STAGES == 0
- Sub-module cla_slice (combinational, parametrised by SLICE): per-bit generate/propagate, group lookahead, sum, carry out, and carry into the slice MSB (needed for ovf).
- The top instantiates STAGES copies of cla_slice plus the skew/de-skew registers and the valid chain.

Test Plan (WIDTH=32, STAGES=4, SAT_EN=1):
- Carry across all slices: a=0x0000FFFF, b=0x00000001, cin=0, sub=0 → 4 clocks later out=0x00010000, cout=0, ovf=0. Then a=0xFFFFFFFF, b=0, cin=1 → out=0x00000000, cout=1, ovf=0.
- Overflow: a=0x7FFFFFFF, b=1, sat=0 → out=0x80000000, ovf=1. Same operands with sat=1 → out=0x7FFFFFFF, ovf=1.
- Subtract: a=5, b=7, sub=1, cin=0 → out=0xFFFFFFFE, cout=0. Then a=0x80000000, b=1, sub=1, sat=1 → out=0x80000000, ovf=1, cout=1.
- Back-pressure: stream 64 random transactions with random in_valid and random out_ready (50%) → results match the reference model in order; out is stable while stalled; in_ready == ~out_valid | out_ready every cycle.
- Reset mid-operation: accept 3 transactions, assert rst_n=0 asynchronously between edges → out_valid=0 immediately. After release, none of the 3 results appear.
- Full throughput: in_valid=1 and out_ready=1 for 20 clocks → 20 results on consecutive clocks starting at clock 4, with alternating sub and sat per transaction.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder/subtractor.
package addsub_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;
  localparam int MAX_WIDTH  = 256;

  localparam logic [MAX_WIDTH-1:0] ONE = MAX_WIDTH'(1);

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
    return (ONE << (width - 1)) - ONE;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
    return ONE << (width - 1);
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= 8) && (width % stages == 0) &&
           (width / stages >= 4) && (width <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational carry-lookahead adder for one operand slice; also exposes the
// carry into the slice MSB so the top slice can form the signed overflow flag.
module cla_slice
  import addsub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is built from the group generate/propagate of the bits below
  // it plus ci, so no carry depends on its neighbour's carry.
  always_comb begin : comb_lookahead
    logic gg;
    logic pp;
    c    = '0;
    gg   = 1'b0;
    pp   = 1'b1;
    c[0] = ci;
    for (int i = 0; i < N; i++) begin
      gg       = g[i] | (p[i] & gg);
      pp       = pp & p[i];
      c[i+1]   = gg | (pp & ci);
    end
  end

  assign s     = p ^ c[N-1:0];
  assign co    = c[N];
  assign c_msb = c[N-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one slice per stage, carries and
// remaining operand bits flow forward, finished sum bits are carried alongside.
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int SL = slice_width(WIDTH, STAGES);
  localparam logic [WIDTH-1:0] SAT_MAX_V = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN_V = WIDTH'(sat_min(WIDTH));

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("pipe_addsub: WIDTH must split into STAGES (1..8) slices of at least 4 bits");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             sat_eff;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub ? ~cin : cin;

  if (SAT_EN) begin : g_sat
    assign sat_eff = sat;
  end else begin : g_nosat
    logic unused_sat;
    assign sat_eff    = 1'b0;
    assign unused_sat = sat;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM = WIDTH - k * SL;

    logic [REM-1:0]        op_a;
    logic [REM-1:0]        op_b;
    logic                  c_in;
    logic                  v_in;
    logic                  s_in;
    logic [SL-1:0]         s_slice;
    logic                  c_out;
    logic                  c_msb;
    logic [(k+1)*SL-1:0]   sum_next;

    if (k == 0) begin : g_src
      assign op_a     = a;
      assign op_b     = b_eff;
      assign c_in     = c0;
      assign v_in     = in_valid;
      assign s_in     = sat_eff;
      assign sum_next = s_slice;
    end else begin : g_src
      assign op_a     = g_stage[k-1].g_mid.a_q;
      assign op_b     = g_stage[k-1].g_mid.b_q;
      assign c_in     = g_stage[k-1].g_mid.carry_q;
      assign v_in     = g_stage[k-1].g_mid.valid_q;
      assign s_in     = g_stage[k-1].g_mid.sat_q;
      assign sum_next = {s_slice, g_stage[k-1].g_mid.sum_q};
    end

    cla_slice #(.N(SL)) u_cla (
      .a     (op_a[SL-1:0]),
      .b     (op_b[SL-1:0]),
      .ci    (c_in),
      .s     (s_slice),
      .co    (c_out),
      .c_msb (c_msb)
    );

    if (k < STAGES - 1) begin : g_mid
      logic [REM-SL-1:0]   a_q;
      logic [REM-SL-1:0]   b_q;
      logic [(k+1)*SL-1:0] sum_q;
      logic                carry_q;
      logic                valid_q;
      logic                sat_q;
      logic                unused_c_msb;

      assign unused_c_msb = c_msb;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   valid_q <= 1'b0;
        else if (adv) valid_q <= v_in;
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          a_q     <= op_a[REM-1:SL];
          b_q     <= op_b[REM-1:SL];
          sum_q   <= sum_next;
          carry_q <= c_out;
          sat_q   <= s_in;
        end
      end
    end else begin : g_last
      logic             ovf_raw;
      logic             sat_hit;
      logic [WIDTH-1:0] res;

      // Overflow is only possible with equal effective sign bits, which pick the rail.
      assign ovf_raw = c_msb ^ c_out;
      assign sat_hit = s_in & ovf_raw;

      always_comb begin
        res = sum_next;
        if (sat_hit && !op_a[REM-1] && !op_b[REM-1]) res = SAT_MAX_V;
        else if (sat_hit && op_a[REM-1] && op_b[REM-1]) res = SAT_MIN_V;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          out       <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
        end else if (adv) begin
          out_valid <= v_in;
          if (v_in) begin
            out  <= res;
            cout <= c_out;
            ovf  <= ovf_raw;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub: directed vectors, full-rate streaming,
// random back-pressure and an asynchronous reset in the middle of traffic.
module tb_pipe_addsub;

  localparam int W  = 32;
  localparam int ST = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         sat;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         cout;
  logic         ovf;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(W), .STAGES(ST), .SAT_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [W-1:0] out;
    logic         cout;
    logic         ovf;
    int           acc;
    bit           lat_chk;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         sat;
    logic [W-1:0] out;
    logic         cout;
    logic         ovf;
  } vec_t;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cycle    = 0;
  int           pops     = 0;
  int           pushes   = 0;
  bit           lat_mode = 1'b0;
  bit           stall_prev = 1'b0;
  logic [W-1:0] held_out;
  logic         held_cout;
  logic         held_ovf;
  vec_t         vecs[14];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  function automatic exp_t mk_exp(input logic [W-1:0] o, input logic c, input logic v);
    exp_t e;
    e.out = o; e.cout = c; e.ovf = v; e.acc = 0; e.lat_chk = 1'b0;
    return e;
  endfunction

  // Reference: plain wide addition, overflow judged from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                 input logic ci, input logic su, input logic st);
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   full;
    logic         v;
    logic [W-1:0] o;
    bb   = su ? ~bi : bi;
    cc   = su ? ~ci : ci;
    full = {1'b0, ai} + {1'b0, bb} + {{W{1'b0}}, cc};
    v    = (ai[W-1] == bb[W-1]) && (full[W-1] != ai[W-1]);
    o    = full[W-1:0];
    if (st && v) o = ai[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return mk_exp(o, full[W], v);
  endfunction

  task automatic check_output();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL unexpected_output: got out=%h with nothing pending, expected no output (cycle %0d)", out, cycle);
      return;
    end
    e = exp_q.pop_front();
    pops++;
    check("out", out, e.out);
    check("cout", cout, e.cout);
    check("ovf", ovf, e.ovf);
    if (e.lat_chk) check("latency", cycle - e.acc, ST);
  endtask

  task automatic apply_stimulus(input logic v, input logic [W-1:0] ai, input logic [W-1:0] bi,
                                input logic ci, input logic su, input logic st,
                                input logic ordy, input exp_t e);
    exp_t pe;
    @(negedge clk);
    in_valid  = v;
    a         = ai;
    b         = bi;
    cin       = ci;
    sub       = su;
    sat       = st;
    out_ready = ordy;
    #1;
    cycle++;
    check("in_ready_rule", in_ready, !out_valid || out_ready);
    if (stall_prev) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_out", out, held_out);
      check("stall_cout", cout, held_cout);
      check("stall_ovf", ovf, held_ovf);
    end
    if (out_valid && out_ready) check_output();
    if (in_valid && in_ready) begin
      pe         = e;
      pe.acc     = cycle;
      pe.lat_chk = lat_mode;
      exp_q.push_back(pe);
      pushes++;
    end
    stall_prev = out_valid && !out_ready;
    held_out   = out;
    held_cout  = cout;
    held_ovf   = ovf;
  endtask

  task automatic idle(input logic ordy);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, ordy, mk_exp('0, 1'b0, 1'b0));
  endtask

  task automatic drain();
    int budget;
    budget = 60;
    while (exp_q.size() > 0 && budget > 0) begin
      idle(1'b1);
      budget--;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    logic         rt;
    int           start_pops;
    int           start_push;
    int           budget;

    vecs[0]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[4]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[5]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1};
    vecs[6]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1};
    vecs[8]  = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0, 32'h2143_6587, 1'b0, 1'b0};
    vecs[9]  = '{32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, 1'b0, 32'h0000_000C, 1'b1, 1'b0};
    vecs[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[11] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[12] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0};
    vecs[13] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    cin = 1'b0; sub = 1'b0; sat = 1'b0; out_ready = 1'b0;
    #3;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out", out, 32'h0);
    check("reset_cout", cout, 1'b0);
    check("reset_ovf", ovf, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    lat_mode = 1'b1;
    foreach (vecs[i])
      apply_stimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].sat, 1'b1,
                     mk_exp(vecs[i].out, vecs[i].cout, vecs[i].ovf));
    drain();

    $display("[TB] full throughput, mode changes per transaction");
    start_pops = pops;
    for (int k = 0; k < 20; k++) begin
      ra = (k % 3 == 0) ? 32'h7FFF_FFFF : $urandom;
      rb = (k % 3 == 0) ? 32'h0000_0001 : $urandom;
      rs = k[0];
      rt = k[1];
      apply_stimulus(1'b1, ra, rb, 1'b0, rs, rt, 1'b1, model(ra, rb, 1'b0, rs, rt));
    end
    drain();
    check("tput_count", pops - start_pops, 20);

    $display("[TB] random traffic with back-pressure");
    lat_mode   = 1'b0;
    start_push = pushes;
    start_pops = pops;
    budget     = 3000;
    while (pushes - start_push < 64 && budget > 0) begin
      case ($urandom_range(0, 3))
        0: begin ra = 32'h7FFF_FFF0 + $urandom_range(0, 15); rb = $urandom_range(0, 31); end
        1: begin ra = 32'h8000_0000 + $urandom_range(0, 15); rb = $urandom_range(0, 31); end
        2: begin ra = $urandom_range(0, 65535); rb = $urandom; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      rt = 1'($urandom_range(0, 1));
      apply_stimulus(1'($urandom_range(0, 1)), ra, rb, rc, rs, rt, 1'($urandom_range(0, 1)),
                     model(ra, rb, rc, rs, rt));
      budget--;
    end
    check("random_accepted", pushes - start_push, 64);
    drain();
    check("random_emitted", pops - start_pops, pushes - start_push);

    $display("[TB] asynchronous reset with work in flight");
    for (int k = 0; k < 3; k++) begin
      ra = $urandom;
      rb = $urandom;
      apply_stimulus(1'b1, ra, rb, 1'b0, 1'b0, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0, 1'b0));
    end
    idle(1'b0);
    idle(1'b0);
    check("pre_reset_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", out_valid, 1'b0);
    check("async_reset_out", out, 32'h0);
    check("async_reset_cout", cout, 1'b0);
    check("async_reset_ovf", ovf, 1'b0);
    exp_q.delete();
    stall_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      idle(1'b1);
      check("no_ghost_output", out_valid, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
